// File: rtl/ctx_mem_rd_port.sv
// Context-restore read port: pops word addresses from the RTOS unit and issues OBI reads.
// Optional stall counter output is enabled by defining CTX_RD_STALL_CNT_EN.
module ctx_mem_rd_port #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] rd_addr_i,
  input  logic        rd_addr_rdy_i,
  output logic        rd_addr_en_o,
  output logic [31:0] rd_data_o,
  output logic        rd_data_en_o,
  input  logic        core_busy_i,
  output logic        bus_own_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef CTX_RD_STALL_CNT_EN
  ,
  output logic [31:0] rd_stall_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic          r_rd_data_en;
  logic [31:0]   r_rd_data;

  logic          w_gnt_acc;
  logic          w_rv_acc;
  logic [CW:0]   w_cnt_sum;
  logic          w_room;
  logic          w_can_issue;
  logic          w_pop;

  assign w_gnt_acc = (r_state == REQ) & mem_gnt_i;
  assign w_rv_acc  = mem_rvalid_i & (r_cnt != '0);

  // A read granted this cycle already occupies a slot for the next pop.
  assign w_cnt_sum   = {1'b0, r_cnt} + {{CW{1'b0}}, w_gnt_acc};
  assign w_room      = w_cnt_sum < (CW + 1)'(MAX_OUTSTANDING);
  assign bus_own_o   = (r_state == REQ) | (r_cnt != '0);
  assign w_can_issue = rd_addr_rdy_i & (bus_own_o | ~core_busy_i) & w_room;
  assign w_pop       = w_can_issue & ((r_state == IDLE) | w_gnt_acc);

  assign rd_addr_en_o = w_pop;
  assign mem_req_o    = (r_state == REQ);
  assign mem_addr_o   = r_addr & 32'hFFFF_FFFC;
  assign rd_data_en_o = r_rd_data_en;
  assign rd_data_o    = r_rd_data;

  // Request FSM: an ungranted request keeps its address until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_addr  <= rd_addr_i;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_pop) begin
            r_addr  <= rd_addr_i;
            r_state <= REQ;
          end else if (mem_gnt_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      case ({w_gnt_acc, w_rv_acc})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Responses with nothing outstanding are dropped here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data_en <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_data_en <= w_rv_acc;
      if (w_rv_acc) begin
        r_rd_data <= mem_rdata_i;
      end
    end
  end

`ifdef CTX_RD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (rd_addr_rdy_i & ~w_pop & (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign rd_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ctx_mem_rd_port.sv
// Bench for ctx_mem_rd_port: directed scenarios plus randomized traffic against a queue-based model.
module tb_ctx_mem_rd_port;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] rd_addr_i;
  logic        rd_addr_rdy_i;
  logic        rd_addr_en_o;
  logic [31:0] rd_data_o;
  logic        rd_data_en_o;
  logic        core_busy_i;
  logic        bus_own_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef CTX_RD_STALL_CNT_EN
  logic [31:0] rd_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ctx_mem_rd_port #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .rd_addr_i     (rd_addr_i),
    .rd_addr_rdy_i (rd_addr_rdy_i),
    .rd_addr_en_o  (rd_addr_en_o),
    .rd_data_o     (rd_data_o),
    .rd_data_en_o  (rd_data_en_o),
    .core_busy_i   (core_busy_i),
    .bus_own_o     (bus_own_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
`ifdef CTX_RD_STALL_CNT_EN
    ,
    .rd_stall_cnt_o(rd_stall_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: addresses the unit offers, popped-but-ungranted, granted-but-unanswered.
  logic [31:0] src_q[$];
  logic [31:0] iss_q[$];
  resp_t       resp_q[$];

  int cyc = 0;
  int gnt_pct = 100, rdy_pct = 100, busy_pct = 0, spur_pct = 0;
  int lat_min = 1, lat_max = 1;
  int busy_force = 0, gnt_block = 0;
  bit use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  bit          exp_den = 1'b0;
  logic [31:0] exp_dat = 32'h0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] stall_mdl = 32'h0;

  int pops = 0, grants = 0, rets = 0, max_out = 0, stall_obs = 0, first_pop_cyc = -1;
  logic [31:0] last_bus_addr = 32'h0;
  logic [31:0] last_ret = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_stall();
`ifdef CTX_RD_STALL_CNT_EN
    chk("stall_cnt", rd_stall_cnt_o, stall_mdl);
`endif
  endtask

  task automatic clear_model();
    src_q.delete();
    iss_q.delete();
    resp_q.delete();
    exp_den    = 1'b0;
    prev_stall = 1'b0;
    stall_mdl  = 32'h0;
    busy_force = 0;
    gnt_block  = 0;
  endtask

  task automatic reset_dut();
    rd_addr_rdy_i = 1'b0;
    rd_addr_i     = 32'h0;
    core_busy_i   = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
    rst_ni        = 1'b0;
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_own", 32'(bus_own_o), 32'd0);
    chk("rst_den", 32'(rd_data_en_o), 32'd0);
    chk("rst_dat", rd_data_o, 32'h0);
    chk("rst_pop", 32'(rd_addr_en_o), 32'd0);
    chk_stall();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: drive one cycle of inputs, check at negedge, advance the model.
  task automatic run_cycle();
    bit    answering;
    bit    grant_now;
    bit    exp_pop;
    bit    exp_own;
    resp_t ans;
    resp_t r;
    if (busy_force > 0) begin
      core_busy_i = 1'b1;
      busy_force--;
    end else begin
      core_busy_i = int'($urandom_range(99)) < busy_pct;
    end
    if (gnt_block > 0) begin
      mem_gnt_i = 1'b0;
      gnt_block--;
    end else begin
      mem_gnt_i = int'($urandom_range(99)) < gnt_pct;
    end
    if (src_q.size() > 0 && int'($urandom_range(99)) < rdy_pct) begin
      rd_addr_rdy_i = 1'b1;
      rd_addr_i     = src_q[0];
    end else begin
      rd_addr_rdy_i = 1'b0;
      rd_addr_i     = $urandom;
    end
    answering = 1'b0;
    ans.data  = 32'h0;
    ans.due   = 0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      ans          = resp_q[0];
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ans.data;
      answering    = 1'b1;
    end else if (resp_q.size() == 0 && int'($urandom_range(99)) < spur_pct) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end

    @(negedge clk);
    exp_own = (iss_q.size() != 0) || (resp_q.size() != 0);
    chk("bus_own", 32'(bus_own_o), 32'(exp_own));
    chk("mem_req", 32'(mem_req_o), 32'(iss_q.size() != 0));
    chk("rd_data_en", 32'(rd_data_en_o), 32'(exp_den));
    if (exp_den) chk("rd_data", rd_data_o, exp_dat);
    if (rd_data_en_o) begin
      last_ret = rd_data_o;
      rets++;
    end
    if (prev_stall) begin
      chk("req_held", 32'(mem_req_o), 32'd1);
      chk("addr_held", mem_addr_o, prev_addr);
    end
    if (mem_req_o && !mem_gnt_i) stall_obs++;

    grant_now = (iss_q.size() != 0) && mem_gnt_i;
    exp_pop = rd_addr_rdy_i && (exp_own || !core_busy_i) &&
              (resp_q.size() + int'(grant_now) < MAXO) &&
              ((iss_q.size() == 0) || grant_now);
    chk("rd_addr_en", 32'(rd_addr_en_o), 32'(exp_pop));
    if (rd_addr_rdy_i && !exp_pop && stall_mdl != 32'hFFFF_FFFF) stall_mdl++;

    exp_den = answering;
    exp_dat = ans.data;
    if (answering) void'(resp_q.pop_front());
    if (grant_now) begin
      chk("mem_addr", mem_addr_o, iss_q[0] & 32'hFFFF_FFFC);
      last_bus_addr = mem_addr_o;
      void'(iss_q.pop_front());
      r.data = use_fixed ? fixed_data : $urandom;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      resp_q.push_back(r);
      if (resp_q.size() > max_out) max_out = resp_q.size();
      grants++;
    end
    if (exp_pop) begin
      iss_q.push_back(src_q[0]);
      void'(src_q.pop_front());
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    prev_stall = mem_req_o && !mem_gnt_i;
    prev_addr  = mem_addr_o;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, g0, r0, s0, c0;
    reset_dut();

    // Single read
    use_fixed = 1'b1;
    fixed_data = 32'hCAFE_F00D;
    lat_min = 2; lat_max = 2;
    p0 = pops; r0 = rets;
    src_q.push_back(32'h0000_1000);
    run_n(8);
    chk("single_pops", 32'(pops - p0), 32'd1);
    chk("single_addr", last_bus_addr, 32'h0000_1000);
    chk("single_data", last_ret, 32'hCAFE_F00D);
    chk("single_rets", 32'(rets - r0), 32'd1);
    chk("single_own_end", 32'(bus_own_o), 32'd0);
    use_fixed = 1'b0;

    // Core busy for 5 cycles
    reset_dut();
    busy_force = 5;
    first_pop_cyc = -1;
    c0 = cyc;
    src_q.push_back(32'h0000_1100);
    run_n(10);
    chk("busy_pop_cyc", 32'(first_pop_cyc - c0), 32'd5);
`ifdef CTX_RD_STALL_CNT_EN
    chk("busy_stall5", rd_stall_cnt_o, 32'd5);
`endif
    chk_stall();

    // Grant stall with core busy rising meanwhile
    lat_min = 1; lat_max = 3;
    gnt_block = 5;
    s0 = stall_obs; g0 = grants; r0 = rets;
    src_q.push_back(32'h0000_3006);
    run_cycle();
    busy_force = 3;
    run_n(10);
    chk("gstall_cycles", 32'(stall_obs - s0), 32'd4);
    chk("gstall_grants", 32'(grants - g0), 32'd1);
    chk("gstall_rets", 32'(rets - r0), 32'd1);
    chk("gstall_addr", last_bus_addr, 32'h0000_3004);

    // Outstanding limit
    lat_min = 3; lat_max = 3;
    max_out = 0;
    p0 = pops; r0 = rets;
    for (int i = 0; i < 4; i++) src_q.push_back(32'h0000_2000 + 32'(4 * i));
    run_n(25);
    chk("limit_max_out", 32'(max_out), 32'(MAXO));
    chk("limit_pops", 32'(pops - p0), 32'd4);
    chk("limit_rets", 32'(rets - r0), 32'd4);
    chk_stall();

    // Spurious rvalid with nothing outstanding
    spur_pct = 100;
    r0 = rets;
    run_n(5);
    chk("spur_rets", 32'(rets - r0), 32'd0);
    chk("spur_own", 32'(bus_own_o), 32'd0);
    spur_pct = 0;

    // Async reset while a request is held
    gnt_block = 10;
    src_q.push_back(32'h0000_4000);
    run_n(3);
    chk("pre_rst_req", 32'(mem_req_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req_o), 32'd0);
    chk("async_rst_own", 32'(bus_own_o), 32'd0);
    clear_model();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    spur_pct = 100;
    r0 = rets;
    run_n(4);
    chk("post_rst_rets", 32'(rets - r0), 32'd0);
    chk_stall();
    spur_pct = 0;

    // Randomized traffic
    max_out = 0;
    for (int k = 0; k < 12; k++) begin
      gnt_pct  = int'($urandom_range(100, 30));
      rdy_pct  = int'($urandom_range(100, 30));
      busy_pct = int'($urandom_range(60, 0));
      spur_pct = int'($urandom_range(20, 0));
      lat_min  = 1;
      lat_max  = int'($urandom_range(5, 1));
      for (int i = 0; i < 300; i++) begin
        if (src_q.size() < 3) src_q.push_back($urandom);
        run_cycle();
      end
      chk_stall();
    end
    chk("rand_max_out_le", 32'(max_out <= MAXO), 32'd1);

    // Drain
    src_q.delete();
    busy_pct = 0; spur_pct = 0; gnt_pct = 100;
    for (int i = 0; i < 60; i++) begin
      if (iss_q.size() == 0 && resp_q.size() == 0 && !exp_den) break;
      run_cycle();
    end
    chk("drain_done", 32'(iss_q.size() + resp_q.size() + int'(exp_den)), 32'd0);
    chk("drain_own", 32'(bus_own_o), 32'd0);
    chk_stall();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
